// File: rtl/div_pkg.sv
// Shared types and helpers for the divider arbiter.
// Optional zero-divisor bypass is enabled with DIV_ARB_ZERO_BYPASS_EN.
package div_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} div_arb_state_t;

  localparam int unsigned DIV_NBITS_DEFAULT = 8;

  // First set bit of mask searching upward from ptr+1, wrapping at n (n <= 8).
  function automatic logic [2:0] rr_next(input logic [2:0] ptr, input logic [7:0] mask,
                                         input int unsigned n);
    logic [2:0] win;
    logic       found;
    logic [2:0] idx;
    win   = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= 8; i++) begin
      idx = 3'((32'(ptr) + i) % n);
      if (i <= n && !found && mask[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/div_arbiter_rr_arbiter.sv
// Round-robin winner select with a pointer that advances to the winner on grant.
// No configuration macros; used by div_arbiter (DIV_ARB_ZERO_BYPASS_EN lives there).
module rr_arbiter
  import div_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [NREQ-1:0] req,
  input  logic            grant_en,
  output logic [IDW-1:0]  winner,
  output logic            req_any
);

  logic [IDW-1:0] ptr;

  assign req_any = |req;
  assign winner  = IDW'(rr_next(3'(ptr), 8'(req), NREQ));

  // Reset to the last index so requester 0 wins the first arbitration.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ptr <= IDW'(NREQ - 1);
    end else if (grant_en) begin
      ptr <= winner;
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// Shares one iterative divider among NREQ requesters, round-robin.
// Define DIV_ARB_ZERO_BYPASS_EN to answer b==0 locally with rsp_err set.
module div_arbiter
  import div_pkg::*;
#(
  parameter int unsigned NBITS = DIV_NBITS_DEFAULT,
  parameter int unsigned NREQ  = 4,
  parameter int unsigned IDW   = $clog2(NREQ)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*NBITS-1:0] req_a,
  input  logic [NREQ*NBITS-1:0] req_b,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [NBITS-1:0]      rsp_quotient,
  output logic [NBITS-1:0]      rsp_remainder,
  output logic                  rsp_err,
  output logic [IDW-1:0]        grant_id,
  output logic                  busy,
  output logic [NBITS-1:0]      div_a,
  output logic [NBITS-1:0]      div_b,
  output logic                  div_ivalid,
  input  logic                  div_iready,
  input  logic                  div_ovalid,
  output logic                  div_oready,
  input  logic [NBITS-1:0]      div_quotient,
  input  logic [NBITS-1:0]      div_remainder
);

  div_arb_state_t   state;
  logic [NBITS-1:0] op_a, op_b, res_q, res_r;
  logic [NBITS-1:0] a_sel, b_sel;
  logic [IDW-1:0]   win, grant_q;
  logic [NREQ-1:0]  win_oh, gnt_oh, ready_q;
  logic             req_any, grant_en;

  assign grant_en = (state == IDLE) && req_any;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .clock    (clock),
    .reset    (reset),
    .req      (req_valid),
    .grant_en (grant_en),
    .winner   (win),
    .req_any  (req_any)
  );

  always_comb begin
    a_sel  = '0;
    b_sel  = '0;
    win_oh = '0;
    gnt_oh = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (IDW'(k) == win) begin
        a_sel = req_a[k*NBITS +: NBITS];
        b_sel = req_b[k*NBITS +: NBITS];
      end
      win_oh[k] = (IDW'(k) == win);
      gnt_oh[k] = (IDW'(k) == grant_q);
    end
  end

`ifdef DIV_ARB_ZERO_BYPASS_EN
  logic err_q;
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      op_a    <= '0;
      op_b    <= '0;
      res_q   <= '0;
      res_r   <= '0;
      grant_q <= '0;
      ready_q <= '0;
`ifdef DIV_ARB_ZERO_BYPASS_EN
      err_q   <= 1'b0;
`endif
    end else begin
      ready_q <= '0;
      case (state)
        IDLE: begin
          if (req_any) begin
            op_a    <= a_sel;
            op_b    <= b_sel;
            grant_q <= win;
            ready_q <= win_oh;
`ifdef DIV_ARB_ZERO_BYPASS_EN
            if (b_sel == '0) begin
              state <= RESP;
              res_q <= '1;
              res_r <= a_sel;
              err_q <= 1'b1;
            end else begin
              state <= ISSUE;
            end
`else
            state   <= ISSUE;
`endif
          end
        end
        ISSUE: if (div_iready) state <= WAIT;
        WAIT: begin
          if (div_ovalid) begin
            res_q <= div_quotient;
            res_r <= div_remainder;
            state <= RESP;
          end
        end
        RESP: begin
          if (|(rsp_ready & gnt_oh)) begin
            res_q <= '0;
            res_r <= '0;
`ifdef DIV_ARB_ZERO_BYPASS_EN
            err_q <= 1'b0;
`endif
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready     = ready_q;
  assign rsp_valid     = (state == RESP) ? gnt_oh : '0;
  assign rsp_quotient  = res_q;
  assign rsp_remainder = res_r;
  assign grant_id      = grant_q;
  assign busy          = (state != IDLE);
  assign div_a         = op_a;
  assign div_b         = op_b;
  assign div_ivalid    = (state == ISSUE);
  assign div_oready    = (state == WAIT) && div_ovalid;

endmodule

// File: tb/tb_div_arbiter.sv
// Directed bench for div_arbiter with a behavioural fixed-latency divider.
// Expectations follow DIV_ARB_ZERO_BYPASS_EN when it is defined.
module tb_div_arbiter;

  localparam int NB = 8;
  localparam int NR = 4;
  localparam int LAT = 3;
`ifdef DIV_ARB_ZERO_BYPASS_EN
  localparam int EXP_ERR = 1;
  localparam int EXP_STARTS = 0;
`else
  localparam int EXP_ERR = 0;
  localparam int EXP_STARTS = 1;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [NR-1:0] req_valid = '0, req_ready, rsp_valid, rsp_ready = '0;
  logic [NR*NB-1:0] req_a = '0, req_b = '0;
  logic [NB-1:0] rsp_quotient, rsp_remainder, div_a, div_b, div_quotient, div_remainder;
  logic          rsp_err, busy, div_ivalid, div_iready, div_ovalid, div_oready;
  logic [1:0]    grant_id;

  int n_checks = 0;
  int n_fail = 0;
  int div_starts = 0;

  always #5 clock = ~clock;

  div_arbiter #(.NBITS(NB), .NREQ(NR)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder), .rsp_err(rsp_err),
    .grant_id(grant_id), .busy(busy), .div_a(div_a), .div_b(div_b),
    .div_ivalid(div_ivalid), .div_iready(div_iready), .div_ovalid(div_ovalid),
    .div_oready(div_oready), .div_quotient(div_quotient), .div_remainder(div_remainder)
  );

  // Divider model: accepts when idle, answers LAT cycles later, holds until oready.
  logic dv_busy;
  int   dv_cnt;
  logic [NB-1:0] dv_q, dv_r;
  assign div_iready    = !dv_busy;
  assign div_ovalid    = dv_busy && (dv_cnt == 0);
  assign div_quotient  = dv_q;
  assign div_remainder = dv_r;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      dv_busy <= 1'b0;
      dv_cnt  <= 0;
      dv_q    <= '0;
      dv_r    <= '0;
    end else if (!dv_busy) begin
      if (div_ivalid) begin
        dv_busy    <= 1'b1;
        dv_cnt     <= LAT;
        dv_q       <= (div_b == 0) ? '1 : div_a / div_b;
        dv_r       <= (div_b == 0) ? div_a : div_a % div_b;
        div_starts <= div_starts + 1;
      end
    end else if (dv_cnt > 0) begin
      dv_cnt <= dv_cnt - 1;
    end else if (div_oready) begin
      dv_busy <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic int oh2idx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int rr_model(input int ptr, input logic [NR-1:0] m);
    for (int i = 1; i <= NR; i++) if (m[(ptr + i) % NR]) return (ptr + i) % NR;
    return -1;
  endfunction

  task automatic wait_grant(output int g);
    int n = 0;
    while (req_ready == '0 && n < 200) begin step(); n++; end
    check("grant_timeout", 32'(n < 200), 1);
    g = oh2idx(req_ready);
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (rsp_valid == '0 && lat < 200) begin step(); lat++; end
    check("rsp_timeout", 32'(lat < 200), 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    step();
  endtask

  task automatic do_txn(input int idx, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] eq, input logic [7:0] er, input int eerr,
                        output int lat);
    int g;
    logic extra;
    req_a[idx*NB +: NB] = a;
    req_b[idx*NB +: NB] = b;
    req_valid[idx] = 1'b1;
    wait_grant(g);
    check("grant_idx", g, idx);
    check("grant_id", 32'(grant_id), idx);
    req_valid[idx] = 1'b0;
    extra = 1'b0;
    lat = 0;
    while (rsp_valid == '0 && lat < 200) begin
      step();
      lat++;
      if (req_ready != '0) extra = 1'b1;
    end
    check("rsp_valid", 32'(rsp_valid), 32'(1 << idx));
    check("quotient", 32'(rsp_quotient), 32'(eq));
    check("remainder", 32'(rsp_remainder), 32'(er));
    check("rsp_err", 32'(rsp_err), eerr);
    rsp_ready[idx] = 1'b1;
    step();
    if (req_ready != '0) extra = 1'b1;
    rsp_ready[idx] = 1'b0;
    check("ready_pulse_once", 32'(extra), 0);
    check("idle_after_rsp", 32'(busy), 0);
    check("rsp_cleared", 32'(rsp_valid), 0);
  endtask

  typedef struct {
    int idx;
    logic [7:0] a, b, q, r;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int lat, g, mptr, starts0, max_wait;
    logic stable;
    logic [NR-1:0] mask;
    logic [7:0] cur_a[NR], cur_b[NR];
    int wait_cnt[NR];
    int eq4[NR], er4[NR];

    vecs[0] = '{2, 8'd100, 8'd7,   8'd14,  8'd2};
    vecs[1] = '{0, 8'd255, 8'd1,   8'd255, 8'd0};
    vecs[2] = '{1, 8'd5,   8'd9,   8'd0,   8'd5};
    vecs[3] = '{3, 8'd0,   8'd3,   8'd0,   8'd0};
    vecs[4] = '{1, 8'd255, 8'd255, 8'd1,   8'd0};
    vecs[5] = '{3, 8'd200, 8'd16,  8'd12,  8'd8};
    eq4 = '{66, 50, 40, 33};
    er4 = '{2, 0, 0, 2};

    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_div_ivalid", 32'(div_ivalid), 0);
    check("rst_rsp_bus", {8'd0, rsp_quotient, rsp_remainder, 7'd0, rsp_err}, 0);
    do_reset();

    for (int i = 0; i < 6; i++)
      do_txn(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, 0, lat);

    // Zero divisor
    starts0 = div_starts;
    do_txn(0, 8'd37, 8'd0, 8'd255, 8'd37, EXP_ERR, lat);
    check("zero_div_starts", div_starts - starts0, EXP_STARTS);
`ifdef DIV_ARB_ZERO_BYPASS_EN
    check("zero_bypass_latency", lat, 0);
`endif

    // All four valid together after reset: strict 0,1,2,3 order, idle gap between
    do_reset();
    for (int k = 0; k < NR; k++) begin
      req_a[k*NB +: NB] = 8'd200;
      req_b[k*NB +: NB] = 8'(k + 3);
    end
    req_valid = '1;
    for (int i = 0; i < NR; i++) begin
      wait_grant(g);
      check("rr_seq", g, i);
      req_valid[g] = 1'b0;
      wait_rsp(lat);
      check("rr_seq_q", 32'(rsp_quotient), eq4[g]);
      check("rr_seq_r", 32'(rsp_remainder), er4[g]);
      rsp_ready[g] = 1'b1;
      step();
      rsp_ready[g] = 1'b0;
      check("rr_no_b2b", 32'(req_ready), 0);
    end

    // Response held 10 cycles while another requester waits
    do_reset();
    req_a[1*NB +: NB] = 8'd90;
    req_b[1*NB +: NB] = 8'd9;
    req_valid[1] = 1'b1;
    wait_grant(g);
    req_valid[1] = 1'b0;
    wait_rsp(lat);
    req_a[0 +: NB] = 8'd50;
    req_b[0 +: NB] = 8'd5;
    req_valid[0] = 1'b1;
    rsp_ready = 4'b0001;
    stable = 1'b1;
    repeat (10) begin
      step();
      if (rsp_quotient != 8'd10 || rsp_remainder != 8'd0 || rsp_valid != 4'b0010 ||
          req_ready != '0) stable = 1'b0;
    end
    check("hold_stable", 32'(stable), 1);
    rsp_ready = 4'b0010;
    step();
    rsp_ready = '0;
    check("hold_no_b2b", 32'(req_ready), 0);
    check("hold_idle", 32'(busy), 0);
    step();
    check("hold_next_grant", 32'(req_ready), 32'(4'b0001));
    req_valid[0] = 1'b0;
    wait_rsp(lat);
    check("hold_next_q", 32'(rsp_quotient), 10);
    rsp_ready[0] = 1'b1;
    step();
    rsp_ready = '0;

    // Fairness: 3 always valid, 0 and 1 come and go
    do_reset();
    mptr = NR - 1;
    max_wait = 0;
    for (int k = 0; k < NR; k++) begin
      wait_cnt[k] = 0;
      cur_a[k] = 8'($urandom_range(255, 0));
      cur_b[k] = 8'($urandom_range(255, 1));
      req_a[k*NB +: NB] = cur_a[k];
      req_b[k*NB +: NB] = cur_b[k];
    end
    req_valid = 4'b1001;
    for (int op = 0; op < 100; op++) begin
      wait_grant(g);
      mask = req_valid;
      check("fair_order", g, rr_model(mptr, mask));
      if (g < 0) g = 0;
      mptr = g;
      for (int k = 0; k < NR; k++) begin
        if (k != g && mask[k]) wait_cnt[k]++;
        if (wait_cnt[k] > max_wait) max_wait = wait_cnt[k];
      end
      wait_cnt[g] = 0;
      if (g != 3) req_valid[g] = 1'b0;
      wait_rsp(lat);
      check("fair_q", 32'(rsp_quotient), 32'(cur_a[g] / cur_b[g]));
      check("fair_r", 32'(rsp_remainder), 32'(cur_a[g] % cur_b[g]));
      for (int k = 0; k < NR; k++) begin
        if ((k < 2 && !req_valid[k] && $urandom_range(1, 0) == 1) || (k == 3 && g == 3)) begin
          cur_a[k] = 8'($urandom_range(255, 0));
          cur_b[k] = 8'($urandom_range(255, 1));
          req_a[k*NB +: NB] = cur_a[k];
          req_b[k*NB +: NB] = cur_b[k];
          req_valid[k] = 1'b1;
          wait_cnt[k] = 0;
        end
      end
      rsp_ready[g] = 1'b1;
      step();
      rsp_ready = '0;
    end
    check("fair_max_wait", 32'(max_wait <= NR - 1), 1);

    // Asynchronous reset while the divider is running
    do_reset();
    req_a[2*NB +: NB] = 8'd100;
    req_b[2*NB +: NB] = 8'd7;
    req_valid[2] = 1'b1;
    wait_grant(g);
    req_valid = '0;
    step();
    step();
    check("mid_wait_busy", 32'(busy), 1);
    check("mid_wait_ivalid", 32'(div_ivalid), 0);
    #2 reset = 1'b1;
    #1;
    check("async_rst_ctrl", {24'd0, req_ready, rsp_valid}, 0);
    check("async_rst_flags", {27'd0, busy, rsp_err, div_ivalid, div_oready, 1'b0}, 0);
    check("async_rst_data", {rsp_quotient, rsp_remainder, div_a, div_b}, 0);
    check("async_rst_gid", 32'(grant_id), 0);
    @(negedge clock);
    reset = 1'b0;
    step();
    for (int k = 0; k < NR; k++) begin
      req_a[k*NB +: NB] = 8'd200;
      req_b[k*NB +: NB] = 8'(k + 3);
    end
    req_valid = '1;
    wait_grant(g);
    check("post_rst_grant", g, 0);
    check("post_rst_ivalid", 32'(div_ivalid), 1);
    check("post_rst_ops", {16'd0, div_a, div_b}, {16'd0, 8'd200, 8'd3});
    req_valid = '0;
    wait_rsp(lat);
    check("post_rst_q", 32'(rsp_quotient), 66);
    check("post_rst_r", 32'(rsp_remainder), 2);
    rsp_ready[0] = 1'b1;
    step();
    rsp_ready = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
